// File: rtl/kvs_pkg.sv
// Package: kvs_pkg
// Shared opcode, flag-bit, FSM-state and sizing definitions for the KVS responder.
package kvs_pkg;

    localparam int unsigned KVS_KEY_SIZE  = 96;
    localparam int unsigned KVS_HASH_BITS = 12;
    localparam int unsigned KVS_ENTRY_W   = KVS_KEY_SIZE + 1;

    // Request opcode carried in in_flag[1:0]
    typedef enum logic [1:0] {
        OP_LOOKUP = 2'b00,
        OP_INSERT = 2'b01,
        OP_DELETE = 2'b10,
        OP_RSVD   = 2'b11
    } kvs_op_e;

    // Bit positions inside out_flag
    localparam int unsigned FLG_HIT = 0;
    localparam int unsigned FLG_WR  = 1;
    localparam int unsigned FLG_COL = 2;
    localparam int unsigned FLG_ERR = 3;

    // Table initialisation walk, then normal service
    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } kvs_state_e;

    // A table entry is {valid, key}
    function automatic int unsigned kvs_entry_width(input int unsigned key_size);
        return key_size + 1;
    endfunction

endpackage

// File: rtl/kvs_hash.sv
// Module: kvs_hash
// Combinational XOR-fold of a key into a HASH_BITS-wide table index.
// The final chunk is zero-padded when KEY_SIZE is not a multiple of HASH_BITS.
module kvs_hash
    import kvs_pkg::*;
#(
    parameter int unsigned KEY_SIZE  = KVS_KEY_SIZE,
    parameter int unsigned HASH_BITS = KVS_HASH_BITS
) (
    input  logic [KEY_SIZE-1:0]  key,
    output logic [HASH_BITS-1:0] hash
);

    localparam int unsigned NUM_CHUNKS = (KEY_SIZE + HASH_BITS - 1) / HASH_BITS;
    localparam int unsigned PAD_W      = NUM_CHUNKS * HASH_BITS;

    logic [PAD_W-1:0] key_padded;

    // Fold every HASH_BITS-wide chunk of the padded key together
    always_comb begin
        key_padded                 = '0;
        key_padded[KEY_SIZE-1:0]   = key;
        hash                       = '0;
        for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
            hash = hash ^ key_padded[i*HASH_BITS +: HASH_BITS];
        end
    end

endmodule

// File: rtl/kvs_responder.sv
// Module: kvs_responder
// Direct-mapped key table answering LOOKUP/INSERT/DELETE with a fixed
// three-cycle latency, one request per clock, no backpressure.
// Optional build macro KVS_STATS_EN adds saturating LOOKUP hit/miss counters
// (ports stat_hit, stat_miss).
module kvs_responder
    import kvs_pkg::*;
#(
    parameter int unsigned KEY_SIZE  = KVS_KEY_SIZE,
    parameter int unsigned HASH_BITS = KVS_HASH_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_SIZE-1:0] in_key,
    input  logic [3:0]          in_flag,
    input  logic                in_valid,
    output logic                out_valid,
    output logic [3:0]          out_flag
`ifdef KVS_STATS_EN
    ,
    output logic [31:0]         stat_hit,
    output logic [31:0]         stat_miss
`endif
);

    localparam int unsigned ENTRY_W = kvs_entry_width(KEY_SIZE);
    localparam int unsigned DEPTH   = 2 ** HASH_BITS;

    // FSM
    kvs_state_e           state_q, state_d;
    logic [HASH_BITS-1:0] init_idx_q, init_idx_d;
    logic                 init_wr;

    // Stage 1: registered request and index
    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_err_q, s1_err_d;
    kvs_op_e              s1_op_q, s1_op_d;
    logic [KEY_SIZE-1:0]  s1_key_q, s1_key_d;
    logic [HASH_BITS-1:0] s1_idx_q, s1_idx_d;
    logic [HASH_BITS-1:0] in_hash;

    // Stage 2: RAM data available
    logic                 s2_valid_q, s2_valid_d;
    logic                 s2_err_q, s2_err_d;
    kvs_op_e              s2_op_q, s2_op_d;
    logic [KEY_SIZE-1:0]  s2_key_q, s2_key_d;
    logic [HASH_BITS-1:0] s2_idx_q, s2_idx_d;
    logic [ENTRY_W-1:0]   rd_data_q;

    // Stage 2 resolution
    logic                 s2_fwd;
    logic [ENTRY_W-1:0]   s2_entry;
    logic                 s2_hit;
    logic                 s2_wr_en;
    logic [ENTRY_W-1:0]   s2_wr_data;
    logic [3:0]           s2_flag;

    // Last committed write-back, for requests that read the RAM on the same edge
    logic                 fwd_valid_q, fwd_valid_d;
    logic [HASH_BITS-1:0] fwd_idx_q, fwd_idx_d;
    logic [ENTRY_W-1:0]   fwd_data_q, fwd_data_d;

    // Response
    logic                 out_valid_q, out_valid_d;
    logic [3:0]           out_flag_q, out_flag_d;

    // Table write port
    logic                 wr_en;
    logic [HASH_BITS-1:0] wr_idx;
    logic [ENTRY_W-1:0]   wr_data;
    logic [ENTRY_W-1:0]   mem [DEPTH];

    // in_flag[3:2] carry no meaning for this block
    logic                 unused_flag_hi;
    assign unused_flag_hi = ^in_flag[3:2];

    kvs_hash #(
        .KEY_SIZE  (KEY_SIZE),
        .HASH_BITS (HASH_BITS)
    ) u_hash (
        .key  (in_key),
        .hash (in_hash)
    );

    // Next state: walk every index once clearing it, then serve forever
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        init_wr    = 1'b0;
        case (state_q)
            S_INIT: begin
                init_wr    = 1'b1;
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == '1) begin
                    state_d = S_RUN;
                end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    // Request capture and pipeline advance
    always_comb begin
        s1_valid_d = in_valid;
        s1_err_d   = (state_q == S_INIT) || (in_flag[1:0] == OP_RSVD);
        s1_op_d    = kvs_op_e'(in_flag[1:0]);
        s1_key_d   = in_key;
        s1_idx_d   = in_hash;

        s2_valid_d = s1_valid_q;
        s2_err_d   = s1_err_q;
        s2_op_d    = s1_op_q;
        s2_key_d   = s1_key_q;
        s2_idx_d   = s1_idx_q;
    end

    // Compare against the pre-op entry and decide write-back and response flags
    always_comb begin
        s2_fwd     = fwd_valid_q && (fwd_idx_q == s2_idx_q);
        s2_entry   = s2_fwd ? fwd_data_q : rd_data_q;
        s2_hit     = s2_entry[ENTRY_W-1] && (s2_entry[KEY_SIZE-1:0] == s2_key_q);
        s2_wr_en   = 1'b0;
        s2_wr_data = {1'b0, s2_key_q};
        s2_flag    = '0;
        if (s2_valid_q) begin
            if (s2_err_q) begin
                s2_flag[FLG_ERR] = 1'b1;
            end else begin
                case (s2_op_q)
                    OP_LOOKUP: s2_flag[FLG_HIT] = s2_hit;
                    OP_INSERT: begin
                        if (s2_hit) begin
                            s2_flag[FLG_HIT] = 1'b1;
                        end else if (!s2_entry[ENTRY_W-1]) begin
                            s2_wr_en        = 1'b1;
                            s2_wr_data      = {1'b1, s2_key_q};
                            s2_flag[FLG_WR] = 1'b1;
                        end else begin
                            s2_flag[FLG_COL] = 1'b1;
                        end
                    end
                    OP_DELETE: begin
                        if (s2_hit) begin
                            s2_wr_en         = 1'b1;
                            s2_wr_data       = {1'b0, s2_key_q};
                            s2_flag[FLG_HIT] = 1'b1;
                            s2_flag[FLG_WR]  = 1'b1;
                        end
                    end
                    default: s2_flag[FLG_ERR] = 1'b1;
                endcase
            end
        end

        fwd_valid_d = s2_wr_en;
        fwd_idx_d   = s2_idx_q;
        fwd_data_d  = s2_wr_data;

        out_valid_d = s2_valid_q;
        out_flag_d  = s2_flag;
    end

    // Write port arbitration: the init walk and request write-back never overlap
    always_comb begin
        wr_en   = init_wr || s2_wr_en;
        wr_idx  = init_wr ? init_idx_q : s2_idx_q;
        wr_data = init_wr ? '0 : s2_wr_data;
    end

    // Simple dual-port table; a read on the write edge returns the old word,
    // which the forwarding register above covers
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        rd_data_q <= mem[s1_idx_q];
    end

    // Control state with synchronous reset; in-flight requests are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            init_idx_q  <= '0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            fwd_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_flag_q  <= '0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            fwd_valid_q <= fwd_valid_d;
            out_valid_q <= out_valid_d;
            out_flag_q  <= out_flag_d;
        end
    end

    // Datapath registers, qualified by the valids above
    always_ff @(posedge clk) begin
        s1_err_q   <= s1_err_d;
        s1_op_q    <= s1_op_d;
        s1_key_q   <= s1_key_d;
        s1_idx_q   <= s1_idx_d;
        s2_err_q   <= s2_err_d;
        s2_op_q    <= s2_op_d;
        s2_key_q   <= s2_key_d;
        s2_idx_q   <= s2_idx_d;
        fwd_idx_q  <= fwd_idx_d;
        fwd_data_q <= fwd_data_d;
    end

    assign out_valid = out_valid_q;
    assign out_flag  = out_flag_q;

`ifdef KVS_STATS_EN
    logic [31:0] stat_hit_q, stat_hit_d;
    logic [31:0] stat_miss_q, stat_miss_d;
    logic        stat_lookup;

    // Saturating LOOKUP hit/miss counts, taken on the response edge
    always_comb begin
        stat_hit_d  = stat_hit_q;
        stat_miss_d = stat_miss_q;
        stat_lookup = s2_valid_q && !s2_err_q && (s2_op_q == OP_LOOKUP) && (state_q == S_RUN);
        if (stat_lookup) begin
            if (s2_hit) begin
                if (stat_hit_q != '1) stat_hit_d = stat_hit_q + 32'd1;
            end else begin
                if (stat_miss_q != '1) stat_miss_d = stat_miss_q + 32'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hit_q  <= '0;
            stat_miss_q <= '0;
        end else begin
            stat_hit_q  <= stat_hit_d;
            stat_miss_q <= stat_miss_d;
        end
    end

    assign stat_hit  = stat_hit_q;
    assign stat_miss = stat_miss_q;
`endif

endmodule

// File: tb/tb_kvs_responder.sv
// Testbench: tb_kvs_responder
// Directed and randomized checks of kvs_responder against a behavioural table model.
// Build with KVS_STATS_EN defined to also check the hit/miss counters.
module tb_kvs_responder;

    localparam int unsigned DEPTH = 4096;
    localparam logic [95:0] K1 = 96'h0A000001_0A000002_1F90_0050;
    localparam logic [95:0] K2 = 96'h0A000001_0A000002_1F90_1051; // same fold as K1
    localparam logic [95:0] K3 = 96'h0B000001_0A000002_1F90_0051; // different fold
    localparam logic [3:0]  F_LOOKUP = 4'b0000;
    localparam logic [3:0]  F_INSERT = 4'b0001;
    localparam logic [3:0]  F_DELETE = 4'b0010;
    localparam logic [3:0]  F_RSVD   = 4'b0011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [95:0] in_key = '0;
    logic [3:0]  in_flag = '0;
    logic        in_valid = 1'b0;
    logic        out_valid;
    logic [3:0]  out_flag;
`ifdef KVS_STATS_EN
    logic [31:0] stat_hit;
    logic [31:0] stat_miss;
`endif

    kvs_responder #(
        .KEY_SIZE  (96),
        .HASH_BITS (12)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_key    (in_key),
        .in_flag   (in_flag),
        .in_valid  (in_valid),
        .out_valid (out_valid),
        .out_flag  (out_flag)
`ifdef KVS_STATS_EN
        ,
        .stat_hit  (stat_hit),
        .stat_miss (stat_miss)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Clock edges seen with rst low; the first DEPTH of them belong to table init
    int unsigned run_edges = 0;
    always @(posedge clk) begin
        if (rst) run_edges <= 0;
        else     run_edges <= run_edges + 1;
    end

    // Behavioural table: slot -> {valid, key}
    bit          m_valid [DEPTH];
    logic [95:0] m_key   [DEPTH];
    int unsigned m_hits;
    int unsigned m_misses;

    function automatic logic [11:0] ref_hash(input logic [95:0] k);
        logic [11:0] h;
        h = '0;
        for (int i = 0; i < 96; i++) h[i % 12] = h[i % 12] ^ k[i];
        return h;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_valid[i] = 1'b0;
            m_key[i]   = '0;
        end
        m_hits   = 0;
        m_misses = 0;
    endfunction

    function automatic logic [3:0] model_apply(input logic [95:0] k, input logic [3:0] f, input bit in_init);
        logic [11:0] h;
        bit          hit;
        h   = ref_hash(k);
        hit = m_valid[h] && (m_key[h] == k);
        if (in_init || f[1:0] == 2'b11) return 4'b1000;
        case (f[1:0])
            2'b00: begin
                if (hit) m_hits++; else m_misses++;
                return {3'b000, hit};
            end
            2'b01: begin
                if (hit) return 4'b0001;
                if (!m_valid[h]) begin
                    m_valid[h] = 1'b1;
                    m_key[h]   = k;
                    return 4'b0010;
                end
                return 4'b0100;
            end
            default: begin
                if (hit) begin
                    m_valid[h] = 1'b0;
                    return 4'b0011;
                end
                return 4'b0000;
            end
        endcase
    endfunction

    typedef struct {
        bit          v;
        logic [95:0] key;
        logic [3:0]  flag;
    } req_t;

    req_t       reqs[$];
    logic       obs_v[$];
    logic [3:0] obs_f[$];
    bit         exp_v[$];
    logic [3:0] exp_f[$];

    function automatic void add_req(input bit v, input logic [95:0] k, input logic [3:0] f);
        req_t r;
        r.v    = v;
        r.key  = k;
        r.flag = f;
        reqs.push_back(r);
    endfunction

    // Stream reqs one per cycle, record every output cycle, and place the
    // model's answer three cycles after each request
    task automatic run_seq();
        int n = reqs.size();
        obs_v.delete(); obs_f.delete(); exp_v.delete(); exp_f.delete();
        for (int i = 0; i < n + 4; i++) begin
            exp_v.push_back(1'b0);
            exp_f.push_back(4'b0000);
        end
        for (int i = 0; i < n + 4; i++) begin
            @(negedge clk);
            obs_v.push_back(out_valid);
            obs_f.push_back(out_flag);
            if (i < n) begin
                in_valid = reqs[i].v;
                in_key   = reqs[i].key;
                in_flag  = reqs[i].flag;
                if (reqs[i].v) begin
                    exp_v[i+3] = 1'b1;
                    exp_f[i+3] = model_apply(reqs[i].key, reqs[i].flag, run_edges < DEPTH);
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (out_flag !== 4'b0000) begin errors++; $display("FAIL reset_out_flag: got %b want 0000", out_flag); end
`ifdef KVS_STATS_EN
        checks++;
        if (stat_hit !== 32'd0 || stat_miss !== 32'd0) begin
            errors++; $display("FAIL reset_stats: got hit=%0d miss=%0d want 0/0", stat_hit, stat_miss);
        end
`endif
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_init();
        logic [3:0] want[$];
        int k;
        // Requests during the init walk, then the first LOOKUPs around the boundary
        reqs.delete();
        for (int i = 0; i < 8; i++) add_req(1'b0, '0, '0);
        add_req(1'b1, K1, F_LOOKUP);
        add_req(1'b1, K1, F_INSERT);
        want = '{4'b1000, 4'b1000};
        run_seq();
        k = 0;
        for (int j = 0; j < obs_v.size(); j++) begin
            checks++;
            if (obs_v[j] !== exp_v[j]) begin errors++; $display("FAIL init_valid c%0d: got %b want %b", j, obs_v[j], exp_v[j]); end
            if (exp_v[j]) begin
                checks++;
                if (obs_f[j] !== want[k]) begin errors++; $display("FAIL init_flag r%0d: got %b want %b", k, obs_f[j], want[k]); end
                k++;
            end
        end
        for (int w = 0; w < int'(DEPTH) + 16 && run_edges < DEPTH - 2; w++) @(negedge clk);
        reqs.delete();
        add_req(1'b1, K1, F_LOOKUP); // last init cycle
        add_req(1'b1, K1, F_LOOKUP); // first run cycle
        want = '{4'b1000, 4'b0000};
        run_seq();
        k = 0;
        for (int j = 0; j < obs_v.size(); j++) begin
            checks++;
            if (obs_v[j] !== exp_v[j]) begin errors++; $display("FAIL boundary_valid c%0d: got %b want %b", j, obs_v[j], exp_v[j]); end
            if (exp_v[j]) begin
                checks++;
                if (obs_f[j] !== want[k]) begin errors++; $display("FAIL boundary_flag r%0d: got %b want %b", k, obs_f[j], want[k]); end
                k++;
            end
        end
    endtask

    task automatic test_insert_lookup();
        logic [3:0] want[$];
        int k;
        reqs.delete();
        add_req(1'b1, K1, F_INSERT);
        add_req(1'b0, '0, '0);
        add_req(1'b0, '0, '0);
        add_req(1'b1, K1, F_LOOKUP);
        add_req(1'b0, '0, '0);
        add_req(1'b1, K1, F_INSERT);
        want = '{4'b0010, 4'b0001, 4'b0001};
        run_seq();
        k = 0;
        for (int j = 0; j < obs_v.size(); j++) begin
            checks++;
            if (obs_v[j] !== exp_v[j]) begin errors++; $display("FAIL ins_lkp_valid c%0d: got %b want %b", j, obs_v[j], exp_v[j]); end
            if (exp_v[j]) begin
                checks++;
                if (obs_f[j] !== want[k]) begin errors++; $display("FAIL ins_lkp_flag r%0d: got %b want %b", k, obs_f[j], want[k]); end
                k++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] want[$];
        int k;
        reqs.delete();
        add_req(1'b1, K1, F_DELETE);
        for (int i = 0; i < 3; i++) add_req(1'b0, '0, '0);
        add_req(1'b1, K1, F_INSERT);
        add_req(1'b1, K1, F_LOOKUP);
        add_req(1'b1, K1, F_DELETE);
        add_req(1'b1, K1, F_LOOKUP);
        want = '{4'b0011, 4'b0010, 4'b0001, 4'b0011, 4'b0000};
        run_seq();
        k = 0;
        for (int j = 0; j < obs_v.size(); j++) begin
            checks++;
            if (obs_v[j] !== exp_v[j]) begin errors++; $display("FAIL b2b_valid c%0d: got %b want %b", j, obs_v[j], exp_v[j]); end
            if (exp_v[j]) begin
                checks++;
                if (obs_f[j] !== want[k]) begin errors++; $display("FAIL b2b_flag r%0d: got %b want %b", k, obs_f[j], want[k]); end
                k++;
            end
        end
    endtask

    task automatic test_collision();
        logic [3:0] want[$];
        int k;
        reqs.delete();
        add_req(1'b1, K1, F_INSERT);
        add_req(1'b1, K2, F_INSERT);
        add_req(1'b1, K2, F_LOOKUP);
        add_req(1'b1, K1, F_LOOKUP);
        add_req(1'b1, K2, F_DELETE);
        add_req(1'b1, K1, F_DELETE);
        want = '{4'b0010, 4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0011};
        run_seq();
        k = 0;
        for (int j = 0; j < obs_v.size(); j++) begin
            checks++;
            if (obs_v[j] !== exp_v[j]) begin errors++; $display("FAIL col_valid c%0d: got %b want %b", j, obs_v[j], exp_v[j]); end
            if (exp_v[j]) begin
                checks++;
                if (obs_f[j] !== want[k]) begin errors++; $display("FAIL col_flag r%0d: got %b want %b", k, obs_f[j], want[k]); end
                k++;
            end
        end
    endtask

    task automatic test_reserved();
        logic [3:0] want[$];
        int k;
        reqs.delete();
        add_req(1'b1, K1, F_INSERT);
        add_req(1'b1, K1, F_RSVD);
        add_req(1'b1, K1, 4'b1111);
        add_req(1'b1, K1, 4'b1100);       // upper bits ignored -> LOOKUP
        add_req(1'b1, K3, F_RSVD);
        add_req(1'b0, '0, '0);
        add_req(1'b1, K3, F_LOOKUP);
        add_req(1'b1, K1, 4'b0110);       // DELETE
        want = '{4'b0010, 4'b1000, 4'b1000, 4'b0001, 4'b1000, 4'b0000, 4'b0011};
        run_seq();
        k = 0;
        for (int j = 0; j < obs_v.size(); j++) begin
            checks++;
            if (obs_v[j] !== exp_v[j]) begin errors++; $display("FAIL rsvd_valid c%0d: got %b want %b", j, obs_v[j], exp_v[j]); end
            if (exp_v[j]) begin
                checks++;
                if (obs_f[j] !== want[k]) begin errors++; $display("FAIL rsvd_flag r%0d: got %b want %b", k, obs_f[j], want[k]); end
                k++;
            end
        end
    endtask

    task automatic test_random();
        logic [95:0] pool [8];
        logic [95:0] m;
        logic [11:0] r;
        int unsigned opn;
        logic [1:0]  op;
        // Four random keys plus a same-slot partner for each
        for (int i = 0; i < 4; i++) begin
            pool[i]   = {$urandom, $urandom, $urandom};
            r         = 12'($urandom_range(1, 4095));
            m         = '0;
            m[11:0]   = r;
            m[23:12]  = r;
            pool[i+4] = pool[i] ^ m;
        end
        reqs.delete();
        for (int i = 0; i < 400; i++) begin
            opn = $urandom_range(0, 9);
            op  = (opn < 4) ? 2'b00 : (opn < 7) ? 2'b01 : (opn < 9) ? 2'b10 : 2'b11;
            add_req($urandom_range(0, 4) != 0, pool[$urandom_range(0, 7)], {2'($urandom_range(0, 3)), op});
        end
        run_seq();
        for (int j = 0; j < obs_v.size(); j++) begin
            checks++;
            if (obs_v[j] !== exp_v[j]) begin errors++; $display("FAIL rand_valid c%0d: got %b want %b", j, obs_v[j], exp_v[j]); end
            if (exp_v[j]) begin
                checks++;
                if (obs_f[j] !== exp_f[j]) begin errors++; $display("FAIL rand_flag c%0d: got %b want %b", j, obs_f[j], exp_f[j]); end
            end
        end
`ifdef KVS_STATS_EN
        checks++;
        if (stat_hit !== m_hits) begin errors++; $display("FAIL rand_stat_hit: got %0d want %0d", stat_hit, m_hits); end
        checks++;
        if (stat_miss !== m_misses) begin errors++; $display("FAIL rand_stat_miss: got %0d want %0d", stat_miss, m_misses); end
`endif
    endtask

    task automatic test_mid_reset();
        logic [3:0] want[$];
        int k;
        reqs.delete();
        add_req(1'b1, K1, F_INSERT);
        run_seq();
        for (int j = 0; j < obs_v.size(); j++) begin
            checks++;
            if (obs_v[j] !== exp_v[j]) begin errors++; $display("FAIL prerst_valid c%0d: got %b want %b", j, obs_v[j], exp_v[j]); end
            if (exp_v[j]) begin
                checks++;
                if (obs_f[j] !== exp_f[j]) begin errors++; $display("FAIL prerst_flag c%0d: got %b want %b", j, obs_f[j], exp_f[j]); end
            end
        end
        // Two requests in flight when reset arrives
        @(negedge clk); in_valid = 1'b1; in_key = K1; in_flag = F_LOOKUP;
        @(negedge clk); in_valid = 1'b1; in_key = K3; in_flag = F_INSERT;
        @(negedge clk); in_valid = 1'b0; rst = 1'b1;
        model_reset();
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid c%0d: got %b want 0", j, out_valid); end
            if (j == 1) rst = 1'b0;
        end
`ifdef KVS_STATS_EN
        checks++;
        if (stat_hit !== 32'd0 || stat_miss !== 32'd0) begin
            errors++; $display("FAIL midrst_stats: got hit=%0d miss=%0d want 0/0", stat_hit, stat_miss);
        end
`endif
        for (int w = 0; w < int'(DEPTH) + 16 && run_edges < DEPTH + 1; w++) @(negedge clk);
        reqs.delete();
        add_req(1'b1, K1, F_LOOKUP);
        add_req(1'b1, K3, F_LOOKUP);
        want = '{4'b0000, 4'b0000};
        run_seq();
        k = 0;
        for (int j = 0; j < obs_v.size(); j++) begin
            checks++;
            if (obs_v[j] !== exp_v[j]) begin errors++; $display("FAIL postrst_valid c%0d: got %b want %b", j, obs_v[j], exp_v[j]); end
            if (exp_v[j]) begin
                checks++;
                if (obs_f[j] !== want[k]) begin errors++; $display("FAIL postrst_flag r%0d: got %b want %b", k, obs_f[j], want[k]); end
                k++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_insert_lookup();
        test_back_to_back();
        test_collision();
        test_reserved();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
